// File: rtl/irq_controller_if.sv
// Register-port bundle for irq_controller: one-cycle strobe, no wait states,
// read data registered and held until the next read.
interface irq_controller_if;
  logic        reg_en;
  logic        reg_write;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_en, reg_write, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_en, reg_write, reg_addr, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority external interrupt controller with claim/complete handshake.
// Define IRQ_SYNC_EN to put a 2-flop synchroniser on every src line.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  irq_controller_if.slave    bus,
  output logic               ext_int
);

  logic [NUM_SRC-1:0] enable, edge_mode, pending, in_service, prev;
  logic [NUM_SRC-1:0] pending_n, in_service_n;
  logic [NUM_SRC-1:0] level, cand, claim_mask;
  logic [4:0]         claim_id, cid;
  logic               claim_valid, rd, wr, claim, complete, w1c, edge_wr;
  logic               unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_p0, sync_p1;

  // Synchroniser stage boundary: src -> sync_p0 -> sync_p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
    end
  end
  assign level = sync_p1;
`else
  assign level = src;
`endif

  assign rd       = bus.reg_en & ~bus.reg_write;
  assign wr       = bus.reg_en &  bus.reg_write;
  assign cid      = bus.reg_wdata[4:0];
  assign cand     = pending & enable & ~in_service;
  assign claim    = rd & (bus.reg_addr == 2'd3) & claim_valid;
  assign complete = wr & (bus.reg_addr == 2'd3);
  assign w1c      = wr & (bus.reg_addr == 2'd2);
  assign edge_wr  = wr & (bus.reg_addr == 2'd1);
  assign unused_wdata = ^bus.reg_wdata;

  // Lowest-numbered candidate wins: scan downward so the last hit is the lowest id.
  always_comb begin
    claim_valid = |cand;
    claim_mask  = '0;
    claim_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
        claim_id      = i[4:0];
      end
    end
  end

  // A fresh edge outranks a claim or W1C clear; a mode change always clears.
  always_comb begin
    pending_n    = pending;
    in_service_n = in_service;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_mode[i]) begin
        if (claim && claim_mask[i])       pending_n[i] = 1'b0;
        if (w1c && bus.reg_wdata[i])      pending_n[i] = 1'b0;
        if (level[i] && !prev[i])         pending_n[i] = 1'b1;
      end else begin
        pending_n[i] = level[i];
      end
      if (edge_wr && (bus.reg_wdata[i] != edge_mode[i])) pending_n[i] = 1'b0;
      if (claim && claim_mask[i])         in_service_n[i] = 1'b1;
      if (complete && (cid == i[4:0]))    in_service_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable        <= '0;
      edge_mode     <= '0;
      pending       <= '0;
      in_service    <= '0;
      prev          <= '0;
      ext_int       <= 1'b0;
      bus.reg_rdata <= '0;
    end else begin
      prev       <= level;
      pending    <= pending_n;
      in_service <= in_service_n;
      ext_int    <= |cand;
      if (wr && (bus.reg_addr == 2'd0)) enable    <= bus.reg_wdata[NUM_SRC-1:0];
      if (edge_wr)                      edge_mode <= bus.reg_wdata[NUM_SRC-1:0];
      if (rd) begin
        case (bus.reg_addr)
          2'd0:    bus.reg_rdata <= 32'(enable);
          2'd1:    bus.reg_rdata <= 32'(edge_mode);
          2'd2:    bus.reg_rdata <= 32'(pending);
          default: bus.reg_rdata <= claim_valid ? 32'(claim_id) + 32'd1 : 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC = 8).
module tb_irq_controller;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       ext_int;
  int         n_cmp = 0;
  int         n_fail = 0;

  irq_controller_if bus ();

  irq_controller #(.NUM_SRC(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .bus     (bus),
    .ext_int (ext_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
    bus.reg_en = 1'b1; bus.reg_write = 1'b1; bus.reg_addr = addr; bus.reg_wdata = data;
    tick();
    bus.reg_en = 1'b0; bus.reg_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] addr, output logic [31:0] data);
    bus.reg_en = 1'b1; bus.reg_write = 1'b0; bus.reg_addr = addr;
    tick();
    bus.reg_en = 1'b0;
    data = bus.reg_rdata;
  endtask

  task automatic do_reset();
    src = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; src = 8'hFF;
    bus.reg_en = 1'b0; bus.reg_write = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = '0;
    repeat (3) tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL reset_ext_int: got %b want 0", ext_int); end
    n_cmp++; if (bus.reg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.reg_rdata); end
    src = 8'h00;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL reset_ext_int_after: got %b want 0", ext_int); end
  endtask

  task automatic test_edge_claim();
    logic [31:0] d;
    do_reset();
    wr_reg(2'd0, 32'h04);
    wr_reg(2'd1, 32'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL edge_early: got %b want 0", ext_int); end
    repeat (LAT) tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL edge_pre_rise: got %b want 0", ext_int); end
    tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL edge_rise: got %b want 1", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL edge_claim: got %0d want 3", d); end
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL edge_claim_same_cycle: got %b want 1", ext_int); end
    tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL edge_fall: got %b want 0", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL edge_claim2: got %0d want 0", d); end
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_pending_cleared: got %h want 0", d); end
    wr_reg(2'd3, 32'd2);
    tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL edge_after_complete: got %b want 0", ext_int); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    do_reset();
    wr_reg(2'd0, 32'hFF);
    src = 8'h0A;
    repeat (LAT + 2) tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL prio_ext_int: got %b want 1", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL prio_claim1: got %0d want 2", d); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd4) begin n_fail++; $display("FAIL prio_claim2: got %0d want 4", d); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL prio_claim3: got %0d want 0", d); end
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL prio_all_claimed: got %b want 0", ext_int); end
    wr_reg(2'd3, 32'd1);
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL prio_reclaim: got %0d want 2", d); end
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL prio_level_reassert: got %b want 1", ext_int); end
    tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL prio_reclaim_fall: got %b want 0", ext_int); end
    src = 8'h00;
  endtask

  task automatic test_masking();
    logic [31:0] d;
    do_reset();
    src = 8'h20;
    repeat (LAT + 2) tick();
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h20) begin n_fail++; $display("FAIL mask_pending: got %h want 20", d); end
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL mask_ext_int: got %b want 0", ext_int); end
    wr_reg(2'd0, 32'h20);
    tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL mask_enable: got %b want 1", ext_int); end
    src = 8'h00;
  endtask

  task automatic test_retrigger();
    logic [31:0] d;
    do_reset();
    wr_reg(2'd0, 32'h01);
    wr_reg(2'd1, 32'h01);
    src = 8'h01;
    tick();
    src = 8'h00;
    repeat (LAT + 2) tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL retrig_first: got %b want 1", ext_int); end
    src = 8'h01;
    repeat (LAT) tick();
    rd_reg(2'd3, d);
    src = 8'h00;
    n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL retrig_claim: got %0d want 1", d); end
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h01) begin n_fail++; $display("FAIL retrig_pending: got %h want 01", d); end
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL retrig_in_service: got %b want 0", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL retrig_claim2: got %0d want 0", d); end
    wr_reg(2'd3, 32'd0);
    tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL retrig_complete: got %b want 1", ext_int); end
    wr_reg(2'd2, 32'h01);
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h00) begin n_fail++; $display("FAIL retrig_w1c: got %h want 00", d); end
  endtask

  task automatic test_bad_complete();
    logic [31:0] d;
    do_reset();
    wr_reg(2'd0, 32'hFF);
    src = 8'h10;
    repeat (LAT + 2) tick();
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL bad_claim: got %0d want 5", d); end
    tick();
    wr_reg(2'd3, 32'd9);
    wr_reg(2'd3, 32'd3);
    tick();
    n_cmp++; if (ext_int !== 1'b0) begin n_fail++; $display("FAIL bad_ext_int: got %b want 0", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL bad_still_in_service: got %0d want 0", d); end
    wr_reg(2'd3, 32'd4);
    tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL bad_good_complete: got %b want 1", ext_int); end
  endtask

  task automatic test_reset_in_service();
    logic [31:0] d;
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL ris_claim: got %0d want 5", d); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.reg_rdata !== 32'h0) begin n_fail++; $display("FAIL ris_async_rdata: got %h want 0", bus.reg_rdata); end
    tick();
    reset = 1'b0;
    wr_reg(2'd0, 32'hFF);
    repeat (LAT + 2) tick();
    n_cmp++; if (ext_int !== 1'b1) begin n_fail++; $display("FAIL ris_ext_int: got %b want 1", ext_int); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL ris_reclaim: got %0d want 5", d); end
    src = 8'h00;
  endtask

  initial begin
    test_reset();
    test_edge_claim();
    test_priority();
    test_masking();
    test_retrigger();
    test_bad_complete();
    test_reset_in_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
